// File: rtl/freq_gate_counter.sv
// Gate-window frequency counter: counts rising edges of an asynchronous `sig` over
// GATE_CYCLES clocks and publishes a 4-digit packed BCD result. Optional macro FREQ_OVF_EN.
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sig,
  output logic [15:0] count,
  output logic        valid
`ifdef FREQ_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic {IDLE, GATE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   edge_det;
  logic [31:0]            gate_cnt;
  logic [15:0]            acc;
  logic [15:0]            acc_inc;
  logic [15:0]            acc_nxt;
  logic                   terminal;
`ifdef FREQ_OVF_EN
  logic                   carry;
  logic                   sticky;
  logic                   sticky_nxt;
`endif

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign terminal = (gate_cnt == GATE_CYCLES - 1);
  assign acc_inc  = bcd_inc(acc);

`ifdef FREQ_OVF_EN
  // Carry out of digit 3 only happens from 9999; the accumulator then sticks there.
  assign carry      = (acc == 16'h9999);
  assign sticky_nxt = sticky | (edge_det & carry);
  assign acc_nxt    = (edge_det && !carry) ? acc_inc : acc;
`else
  assign acc_nxt    = edge_det ? acc_inc : acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      acc      <= '0;
      count    <= '0;
      valid    <= 1'b0;
`ifdef FREQ_OVF_EN
      sticky   <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          acc      <= '0;
`ifdef FREQ_OVF_EN
          sticky   <= 1'b0;
`endif
          if (en) state <= GATE;
        end
        GATE: begin
          if (terminal) begin
            // Edge landing on the terminal cycle belongs to the closing window.
            count    <= acc_nxt;
            valid    <= 1'b1;
            gate_cnt <= '0;
            acc      <= '0;
`ifdef FREQ_OVF_EN
            ovf      <= sticky_nxt;
            sticky   <= 1'b0;
`endif
            if (!en) state <= IDLE;
          end else if (!en) begin
            state    <= IDLE;
            gate_cnt <= '0;
            acc      <= '0;
`ifdef FREQ_OVF_EN
            sticky   <= 1'b0;
`endif
          end else begin
            gate_cnt <= gate_cnt + 32'd1;
            acc      <= acc_nxt;
`ifdef FREQ_OVF_EN
            sticky   <= sticky_nxt;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter: two instances (short and long gate window),
// randomized sig/en stimulus, expected results from an integer edge-counting model.
`timescale 1ns/1ps
module tb_freq_gate_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic exp_t expect_of(int c, int n);
    exp_t e;
    e.cyc = c;
`ifdef FREQ_OVF_EN
    e.ovf = (n > 9999);
    e.cnt = (n > 9999) ? 16'h9999 : to_bcd(n);
`else
    e.ovf = 1'b0;
    e.cnt = to_bcd(n % 10000);
`endif
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned G = (g == 0) ? 100 : 22000;
    localparam int unsigned S = (g == 0) ? 2 : 3;

    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        sig   = 1'b0;
    logic        valid;
    logic        ovf;
    logic [15:0] count;
    int          per = 0;
    int          hi  = 0;
    int          ph  = 0;
    bit          done = 1'b0;

    freq_gate_counter #(.GATE_CYCLES(G), .SYNC_STAGES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .sig   (sig),
      .count (count),
      .valid (valid)
`ifdef FREQ_OVF_EN
      ,
      .ovf   (ovf)
`endif
    );
`ifndef FREQ_OVF_EN
    assign ovf = 1'b0;
`endif

    // Periodic sig source: high for `hi` of every `per` clocks.
    always @(negedge clk) begin
      if (per < 2) sig = 1'b0;
      else begin
        ph  = (ph + 1) % per;
        sig = (ph < hi);
      end
    end

    // Reference model: count detected edges per window with plain integers.
    exp_t       q[$];
    logic [7:0] sh  = '0;
    int         cyc = 0;
    int         pos = 0;
    int         n   = 0;
    bit         inw = 1'b0;
    always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
        sh  = '0;
        inw = 1'b0;
        q.delete();
      end else begin
        sh = {sh[6:0], sig};
        if (!inw) begin
          if (en) begin
            inw = 1'b1;
            pos = 0;
            n   = 0;
          end
        end else begin
          pos++;
          n += int'(sh[S] & ~sh[S+1]);
          if (pos == int'(G)) begin
            q.push_back(expect_of(cyc, n));
            inw = en;
            pos = 0;
            n   = 0;
          end else if (!en) inw = 1'b0;
        end
      end
    end

    // Monitor: compare every published result; outside valid, count/ovf must hold.
    logic [15:0] last_cnt = '0;
    logic        last_ovf = 1'b0;
    always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
        last_cnt = '0;
        last_ovf = 1'b0;
      end else if (valid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL lane%0d unexpected_valid cyc=%0d count=%h", g, cyc, count);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.cnt !== count || e.ovf !== ovf) begin
            miscompares++;
            $display("FAIL lane%0d result cyc=%0d count=%h ovf=%b expected cyc=%0d count=%h ovf=%b",
                     g, cyc, count, ovf, e.cyc, e.cnt, e.ovf);
          end
        end
        last_cnt = count;
        last_ovf = ovf;
      end else begin
        vectors++;
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          miscompares++;
          $display("FAIL lane%0d missing_valid cyc=%0d expected count=%h", g, cyc, q[0].cnt);
          void'(q.pop_front());
        end else if (count !== last_cnt || ovf !== last_ovf) begin
          miscompares++;
          $display("FAIL lane%0d hold count=%h ovf=%b expected count=%h ovf=%b",
                   g, count, ovf, last_cnt, last_ovf);
        end
      end
    end

    if (g == 0) begin : stim
      initial begin
        repeat (3) @(negedge clk);
        chk("l0_reset_count", int'(count), 0);
        chk("l0_reset_valid", int'(valid), 0);
        chk("l0_reset_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        per = 7; hi = 3;
        repeat (2 * G + 20) @(negedge clk);
        en = 1'b1; per = 20; hi = 10;
        repeat (5 * G) @(negedge clk);
        // asynchronous reset in the middle of a window with edges flowing
        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("l0_async_rst_count", int'(count), 0);
        chk("l0_async_rst_valid", int'(valid), 0);
        chk("l0_async_rst_ovf", int'(ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * G) @(negedge clk);
        // explicit abort: drop en halfway through a window
        for (int i = 0; i < 2 * int'(G) && !valid; i++) @(negedge clk);
        chk("l0_valid_before_abort", int'(valid), 1);
        repeat (50) @(negedge clk);
        en = 1'b0;
        repeat (30) @(negedge clk);
        en = 1'b1;
        repeat (3 * G) @(negedge clk);
        per = 4; hi = 2;
        repeat (3 * G) @(negedge clk);
        per = 2; hi = 1;
        repeat (3 * G) @(negedge clk);
        while (!lane[1].done) begin
          per = $urandom_range(40, 2);
          hi  = $urandom_range(per - 1, 1);
          if ($urandom_range(3, 0) == 0) begin
            en = 1'b0;
            repeat ($urandom_range(150, 1)) @(negedge clk);
            en = 1'b1;
          end
          repeat ($urandom_range(400, 50)) @(negedge clk);
        end
        en = 1'b0;
        repeat (G + 10) @(negedge clk);
        chk("l0_queue_drained", q.size(), 0);
        done = 1'b1;
      end
    end else begin : stim
      initial begin
        repeat (3) @(negedge clk);
        chk("l1_reset_count", int'(count), 0);
        chk("l1_reset_valid", int'(valid), 0);
        rst_n = 1'b1;
        en = 1'b1; per = 2; hi = 1;
        repeat (G + G / 2) @(negedge clk);
        per = 20; hi = 10;
        repeat (2 * G + 50) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("l1_queue_drained", q.size(), 0);
        done = 1'b1;
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog lane0_done=%0d lane1_done=%0d expected both 1", lane[0].done, lane[1].done);
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait (lane[0].done && lane[1].done);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
